// File: rtl/sdram_ctrl.sv
// Single-word (32-bit over a 16-bit bus, BL=2, CL=2) SDRAM controller with power-up init.
// Optional periodic auto-refresh is enabled with `define SDRAM_CTRL_REFRESH_EN.
module sdram_ctrl #(
   parameter int unsigned INIT_WAIT      = 200,
   parameter int unsigned TRP            = 2,
   parameter int unsigned TRCD           = 2,
   parameter int unsigned TRFC           = 7,
   parameter int unsigned REFRESH_CYCLES = 780
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [24:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        sdram_cke,
   output logic        sdram_cs,
   output logic        sdram_ras,
   output logic        sdram_cas,
   output logic        sdram_we,
   output logic [12:0] sdram_a,
   output logic [1:0]  sdram_ba,
   output logic [1:0]  sdram_dqm,
   output logic [15:0] sdram_dq_out,
   output logic        sdram_dq_oe,
   input  logic [15:0] sdram_dq_in
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_ACT, S_RCD, S_RD, S_RDWAIT,
      S_WR, S_WR2, S_PRE, S_RP, S_REF, S_RFC
   } state_e;

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_LMR   = 4'b0000;

   localparam int CW = 16;
   localparam logic [CW-1:0] ONE    = CW'(1);
   // Init schedule as absolute cycle offsets of a single counter
   localparam logic [CW-1:0] I_PRE  = CW'(INIT_WAIT);
   localparam logic [CW-1:0] I_REF1 = CW'(INIT_WAIT + TRP);
   localparam logic [CW-1:0] I_REF2 = CW'(INIT_WAIT + TRP + TRFC);
   localparam logic [CW-1:0] I_LMR  = CW'(INIT_WAIT + TRP + 2 * TRFC);
   localparam logic [CW-1:0] I_DONE = CW'(INIT_WAIT + TRP + 2 * TRFC + 2);
   localparam logic [CW-1:0] RCD_END = CW'(TRCD - 2);
   localparam logic [CW-1:0] RP_END  = CW'(TRP - 2);
   localparam logic [CW-1:0] RFC_END = CW'(TRFC - 1);
   localparam logic [CW-1:0] RDW_LO  = CW'(1);
   localparam logic [CW-1:0] RDW_HI  = CW'(2);
   localparam logic [15:0]   RC_END  = 16'(REFRESH_CYCLES - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [24:2]     addr_q;
   logic            we_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wmask_q;
   logic [15:0]     lo_q;
   logic [31:0]     rdata_q;
   logic            ref_pend;
   logic            accept;
   logic [3:0]      cmd;
   logic [1:0]      bank;
   logic [12:0]     row;
   logic [8:0]      col;
   logic            unused_addr_lsb;

   assign bank = addr_q[24:23];
   assign row  = addr_q[22:10];
   assign col  = {addr_q[9:2], 1'b0};
   assign unused_addr_lsb = ^req_addr[1:0];

   assign req_ready = (state_q == S_IDLE) && !ref_pend;
   assign accept    = req_valid && req_ready;

`ifdef SDRAM_CTRL_REFRESH_EN
   logic [15:0] rcnt_q, rcnt_d;
   logic        pend_q, pend_d;

   // Clear first so an expiry on the same cycle is not lost
   always_comb begin
      rcnt_d = rcnt_q;
      pend_d = pend_q;
      if (state_q == S_RFC && state_d == S_IDLE) pend_d = 1'b0;
      if (state_q != S_INIT) begin
         if (rcnt_q == RC_END) begin
            rcnt_d = '0;
            pend_d = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rcnt_q <= '0;
         pend_q <= 1'b0;
      end else begin
         rcnt_q <= rcnt_d;
         pend_q <= pend_d;
      end
   end

   assign ref_pend = pend_q;
`else
   logic [15:0] unused_rc;
   assign unused_rc = RC_END;
   assign ref_pend  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:   if (cnt_q == I_DONE) state_d = S_IDLE;
         S_IDLE:   if (ref_pend) state_d = S_REF;
                   else if (req_valid) state_d = S_ACT;
         S_ACT:    state_d = (TRCD > 1) ? S_RCD : (we_q ? S_WR : S_RD);
         S_RCD:    if (cnt_q == RCD_END) state_d = we_q ? S_WR : S_RD;
         S_RD:     state_d = S_RDWAIT;
         S_RDWAIT: if (cnt_q == RDW_HI) state_d = S_PRE;
         S_WR:     state_d = S_WR2;
         S_WR2:    state_d = S_PRE;
         S_PRE:    state_d = (TRP > 1) ? S_RP : S_IDLE;
         S_RP:     if (cnt_q == RP_END) state_d = S_IDLE;
         S_REF:    state_d = S_RFC;
         S_RFC:    if (cnt_q == RFC_END) state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase
   end

   // Per-state cycle counter; INIT keeps counting through its whole schedule
   always_comb begin
      cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr[24:2];
            we_q    <= req_we;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end
         // CL=2: low half lands on the 2nd edge after READ, high half on the 3rd
         if (state_q == S_RDWAIT && cnt_q == RDW_LO) lo_q <= sdram_dq_in;
         if (state_q == S_RDWAIT && cnt_q == RDW_HI) rdata_q <= {sdram_dq_in, lo_q};
      end
   end

   always_comb begin
      cmd          = CMD_NOP;
      sdram_a      = '0;
      sdram_ba     = '0;
      sdram_dqm    = '0;
      sdram_dq_out = '0;
      sdram_dq_oe  = 1'b0;
      rsp_valid    = 1'b0;
      unique case (state_q)
         S_INIT: begin
            if (cnt_q == I_PRE) begin
               cmd     = CMD_PRE;
               sdram_a = 13'h0400;
            end else if (cnt_q == I_REF1 || cnt_q == I_REF2) begin
               cmd = CMD_REF;
            end else if (cnt_q == I_LMR) begin
               cmd     = CMD_LMR;
               sdram_a = 13'h0021;
            end
         end
         S_ACT: begin
            cmd      = CMD_ACT;
            sdram_a  = row;
            sdram_ba = bank;
         end
         S_RD: begin
            cmd      = CMD_READ;
            sdram_a  = {4'b0000, col};
            sdram_ba = bank;
         end
         S_WR: begin
            cmd          = CMD_WRITE;
            sdram_a      = {4'b0000, col};
            sdram_ba     = bank;
            sdram_dqm    = wmask_q[1:0];
            sdram_dq_out = wdata_q[15:0];
            sdram_dq_oe  = 1'b1;
         end
         S_WR2: begin
            sdram_dqm    = wmask_q[3:2];
            sdram_dq_out = wdata_q[31:16];
            sdram_dq_oe  = 1'b1;
         end
         S_PRE: begin
            cmd       = CMD_PRE;
            sdram_ba  = bank;
            rsp_valid = 1'b1;
         end
         S_REF:   cmd = CMD_REF;
         default: ;
      endcase
   end

   assign sdram_cke = 1'b1;
   assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd;
   assign rsp_rdata = rdata_q;

endmodule
